// File: rtl/spi_cfg_seq.sv
// spi_cfg_seq: walks a register table from an external synchronous ROM,
// writes each entry to an SPI device (24-bit mode-0 frames), optionally
// reads each one back with a bounded number of retries, and finishes with
// an update-registers command.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | wait for a rising edge on start_i
// S_FETCH | present tbl_idx_o, latch address/data one cycle later
// S_WR    | write frame for the current entry
// S_RD    | read-back frame (verify runs only)
// S_CHK   | compare read-back data with written data
// S_UPD   | write 8'h01 to UPD_ADDR
// S_FIN   | single cycle, pulse done_o

module spi_cfg_seq #(
    parameter int          NUM_REGS  = 64,
    parameter int          CLK_DIV   = 4,
    parameter int          MAX_RETRY = 2,
    parameter logic [12:0] UPD_ADDR  = 13'h232,
    parameter int          IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic             sys_clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             verify_en_i,
    output logic [IDX_W-1:0] tbl_idx_o,
    input  logic [12:0]      tbl_addr_i,
    input  logic [7:0]       tbl_data_i,
    output logic             spi_cs_n_o,
    output logic             spi_sclk_o,
    output logic             spi_sdio_o,
    input  logic             spi_sdo_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [IDX_W-1:0] err_idx_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WR, S_RD, S_CHK, S_UPD, S_FIN
    } state_t;

    localparam logic [7:0]       DIV_M1   = 8'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    // Half-period slots: 0..47 carry the 24 bits (low half, then high half),
    // 48 is the CS hold after the last falling edge, 49..51 keep CS high.
    localparam logic [5:0]       H_HOLD   = 6'd48;
    localparam logic [5:0]       H_CSUP   = 6'd49;
    localparam logic [5:0]       H_LAST   = 6'd51;

    // sequencer state
    state_t           state_q, state_d;
    logic             fetch_ph_q, fetch_ph_d;
    logic             sent_q, sent_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [12:0]      addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             verify_q, verify_d;
    logic [2:0]       retry_q, retry_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_prev_q, start_prev_d;

    // frame engine state
    logic             run_q, run_d;
    logic [5:0]       half_q, half_d;
    logic [7:0]       div_q, div_d;
    logic [23:0]      shift_q, shift_d;
    logic [7:0]       rx_q, rx_d;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             sdio_q, sdio_d;

    logic             go;
    logic             adv;
    logic [23:0]      frame_word;
    logic             eng_free;
    logic             tail;
    logic             start_edge;
    logic [5:0]       half_nxt;

    assign start_edge = start_i & ~start_prev_q;
    // The engine can take a new frame in the last cycle of the CS-high gap,
    // which keeps back-to-back frames exactly 52 half-periods apart.
    assign eng_free   = ~run_q | ((half_q == H_LAST) && (div_q == 8'd0));
    assign tail       = run_q & cs_n_q & sent_q;
    assign half_nxt   = half_q + 6'd1;

    // Sequencer next-state and frame requests.
    always_comb begin
        state_d      = state_q;
        fetch_ph_d   = fetch_ph_q;
        sent_d       = sent_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
        data_d       = data_q;
        verify_d     = verify_q;
        retry_d      = retry_q;
        err_d        = err_q;
        err_idx_d    = err_idx_q;
        start_prev_d = start_i;
        go           = 1'b0;
        adv          = 1'b0;
        frame_word   = {1'b0, 2'b00, addr_q, data_q};

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d    = S_FETCH;
                    fetch_ph_d = 1'b0;
                    idx_d      = '0;
                    err_d      = 1'b0;
                    err_idx_d  = '0;
                    retry_d    = 3'd0;
                    verify_d   = verify_en_i;
                end
            end
            S_FETCH: begin
                if (!fetch_ph_q) begin
                    fetch_ph_d = 1'b1;
                end else begin
                    fetch_ph_d = 1'b0;
                    addr_d     = tbl_addr_i;
                    data_d     = tbl_data_i;
                    sent_d     = 1'b0;
                    state_d    = S_WR;
                end
            end
            S_WR: begin
                if (!sent_q) begin
                    if (eng_free) begin
                        go     = 1'b1;
                        sent_d = 1'b1;
                    end
                end else if (tail) begin
                    sent_d = 1'b0;
                    if (verify_q) state_d = S_RD;
                    else          adv     = 1'b1;
                end
            end
            S_RD: begin
                frame_word = {1'b1, 2'b00, addr_q, 8'h00};
                if (!sent_q) begin
                    if (eng_free) begin
                        go     = 1'b1;
                        sent_d = 1'b1;
                    end
                end else if (tail) begin
                    sent_d  = 1'b0;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (rx_q == data_q) begin
                    adv = 1'b1;
                end else if (int'(retry_q) < MAX_RETRY) begin
                    retry_d = retry_q + 3'd1;
                    state_d = S_WR;
                end else begin
                    err_d = 1'b1;
                    if (!err_q) err_idx_d = idx_q;
                    adv = 1'b1;
                end
            end
            S_UPD: begin
                frame_word = {1'b0, 2'b00, UPD_ADDR, 8'h01};
                if (!sent_q) begin
                    if (eng_free) begin
                        go     = 1'b1;
                        sent_d = 1'b1;
                    end
                end else if (!run_q) begin
                    sent_d  = 1'b0;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (adv) begin
            if (idx_q == LAST_IDX) begin
                state_d = S_UPD;
            end else begin
                idx_d      = idx_q + 1'b1;
                retry_d    = 3'd0;
                fetch_ph_d = 1'b0;
                state_d    = S_FETCH;
            end
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    // Frame engine: half-period down-counter driving CS, SCLK and SDIO.
    always_comb begin
        run_d   = run_q;
        half_d  = half_q;
        div_d   = div_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        sdio_d  = sdio_q;

        if (go) begin
            run_d   = 1'b1;
            half_d  = 6'd0;
            div_d   = DIV_M1;
            shift_d = frame_word;
            cs_n_d  = 1'b0;
            sclk_d  = 1'b0;
            sdio_d  = frame_word[23];
        end else if (run_q) begin
            if (div_q != 8'd0) begin
                div_d = div_q - 8'd1;
            end else begin
                div_d  = DIV_M1;
                half_d = half_nxt;
                if (half_q == H_LAST) begin
                    run_d  = 1'b0;
                    half_d = 6'd0;
                end else if (half_nxt < H_HOLD) begin
                    sclk_d = half_nxt[0];
                    if (half_nxt[0]) begin
                        rx_d = {rx_q[6:0], spi_sdo_i};
                    end else begin
                        shift_d = {shift_q[22:0], 1'b0};
                        sdio_d  = shift_q[22];
                    end
                end else if (half_nxt == H_HOLD) begin
                    sclk_d = 1'b0;
                    sdio_d = 1'b0;
                end else if (half_nxt == H_CSUP) begin
                    cs_n_d = 1'b1;
                end
            end
        end
    end

    // All state registers; reset forces the bus idle and the sequencer to IDLE.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            fetch_ph_q   <= 1'b0;
            sent_q       <= 1'b0;
            idx_q        <= '0;
            addr_q       <= 13'd0;
            data_q       <= 8'd0;
            verify_q     <= 1'b0;
            retry_q      <= 3'd0;
            err_q        <= 1'b0;
            err_idx_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            start_prev_q <= 1'b1;
            run_q        <= 1'b0;
            half_q       <= 6'd0;
            div_q        <= 8'd0;
            shift_q      <= 24'd0;
            rx_q         <= 8'd0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b0;
            sdio_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_ph_q   <= fetch_ph_d;
            sent_q       <= sent_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            verify_q     <= verify_d;
            retry_q      <= retry_d;
            err_q        <= err_d;
            err_idx_q    <= err_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            start_prev_q <= start_prev_d;
            run_q        <= run_d;
            half_q       <= half_d;
            div_q        <= div_d;
            shift_q      <= shift_d;
            rx_q         <= rx_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            sdio_q       <= sdio_d;
        end
    end

    assign tbl_idx_o  = idx_q;
    assign spi_cs_n_o = cs_n_q;
    assign spi_sclk_o = sclk_q;
    assign spi_sdio_o = sdio_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_idx_o  = err_idx_q;

endmodule
